gf180mcu_clkgate_ctrl: RTL and testbench
========================================

# gf180mcu_clkgate_ctrl

Clock-enable sequencer for a gated clock-buffer branch in the 9-track 5 V library. It arbitrates shared use of one gated branch, driven through an integrated clock-gate cell into a clkbuf tree, among NREQ requesters using a four-phase REQ/ACK handshake. It asserts enable E, waits WAKE_CYCLES for the buffered clock to settle, then grants all active requesters. After the branch goes idle it holds the clock for IDLE_CYCLES before gating it off. It runs on the free-running root clock, upstream of the gate.

## Interface
- NREQ, 4: number of requesters (1..16)
- WAKE_CYCLES, 2: cycles from E rising to first ACK (≥1)
- IDLE_CYCLES, 4: cycles with no REQ in ON before E falls (≥1)
- CLK  in  1  free-running root clock; all state on rising edge
- RST  in  1  reset; asynchronous, active-high
- REQ  in  NREQ  per-requester request; level, four-phase
- ACK  out  NREQ  per-requester grant; registered
- E  out  1  enable to the clock-gate cell; registered
- BUSY  out  1  state ≠ OFF; registered

## Operation
- States: OFF, WAKE, ON, HOLD. Reset state is OFF, with E=0, ACK=0, BUSY=0 and counter=0.
- OFF: E=0, ACK=0.
  - Any REQ bit high at an edge → WAKE, E=1, cnt=WAKE_CYCLES.
- WAKE: E=1, ACK=0. Each edge decrements cnt.
  - At the edge where cnt==1 and REQ≠0 → ON, with ACK=REQ sampled at that edge.
  - At the edge where cnt==1 and REQ==0 → HOLD, cnt=IDLE_CYCLES.
- ON: E=1. At every edge ACK ← REQ, so grants rise and fall one cycle after REQ.
  - The edge sampling REQ==0 → HOLD, ACK=0, cnt=IDLE_CYCLES.
- HOLD: E=1, ACK=0.
  - Any REQ high → ON, ACK=REQ at that edge. No wake delay is needed because the clock is still running.
  - Otherwise cnt decrements. At the edge where cnt==1 → OFF, E=0.
- Simultaneous events:
  - REQ rising on the same edge HOLD would expire: REQ wins, go to ON, E stays 1.
  - REQ arriving in WAKE: waits and is granted at WAKE exit.
- Requester rule: hold REQ until ACK is seen, then drop REQ when done.
  - ACK for a dropped REQ falls on the next edge.
  - A REQ dropped before its ACK is legal. It is simply not granted.
- Counter width is $clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1). It never underflows; it is only loaded on state entry.
- RST mid-operation: immediate return to OFF, E=0, ACK=0. The branch is gated even if grants were outstanding.
- E never toggles more than once per cycle. E falls only in the HOLD→OFF transition.

## Timing
- REQ first sampled high at edge k in OFF:
  - E=1 after edge k.
  - ACK=1 after edge k+WAKE_CYCLES.
- Last REQ sampled low at edge m in ON:
  - ACK=0 after edge m.
  - E=0 after edge m+IDLE_CYCLES, if no new REQ arrives.
- New REQ in ON or HOLD: ACK one cycle later.
- All outputs are register outputs; there are no combinational REQ→ACK paths.

## Configuration
- GF180MCU_CLKGATE_CTRL_TEST_EN compiled in:
  - Adds input TE (1 bit).
  - While TE=1, E is forced to 1 combinationally after the register, so scan/test clocks reach the tree.
  - FSM and ACK behaviour are unchanged.
- Not defined: no TE port, and E is purely the registered FSM output.

## Structure
- Shared package gf180mcu_clkgate_pkg holds:
  - state enum (OFF, WAKE, ON, HOLD)
  - a localparam function for the counter width
- One sub-module, gf180mcu_clkgate_cnt: a loadable down-counter with load value, decrement enable and an is-one flag.
- The top level holds the FSM, ACK register and E/BUSY registers.

## Test plan
All scenarios use NREQ=4, WAKE_CYCLES=2, IDLE_CYCLES=4.
- Cold wake: REQ=0001 at edge 0 → E=1 after edge 0; ACK=0001 after edge 2; BUSY=1.
- Second requester in ON: REQ goes 0001→0101 → ACK=0101 one cycle later, E stays 1.
- Idle timeout: REQ→0000 at edge m → ACK=0000 after m; E=0, BUSY=0 after m+4.
- Rescue in HOLD: REQ=0010 raised at edge m+2 → ON, ACK=0010 after m+2, E never falls.
- Expiry race: REQ=1000 on exactly edge m+4 → stays ON, ACK=1000, E never falls.
- Reset mid-ON: RST pulse while ACK=0011 → E=0, ACK=0000, BUSY=0 immediately; with REQ still high, release RST → wake restarts and ACK follows 2 edges after E.
- With GF180MCU_CLKGATE_CTRL_TEST_EN defined: TE=1 in OFF → E=1 while ACK=0.

Source files
------------

// File: rtl/gf180mcu_clkgate_pkg.sv
// Shared types for the gated-branch clock-enable sequencer: FSM states and counter sizing.
// Combinational helpers only; no latency, no flow control.
package gf180mcu_clkgate_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_ON   = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

   // Wide enough to hold the larger of the two reload values.
   function automatic int cnt_width(input int wake_cycles, input int idle_cycles);
      int max_v;
      max_v = (wake_cycles > idle_cycles) ? wake_cycles : idle_cycles;
      return $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/gf180mcu_clkgate_ctrl_if.sv
// Requester-side bundle: four-phase REQ/ACK per requester plus branch enable and busy status.
// The slave modport is the sequencer; the master modport is the requester population.
interface gf180mcu_clkgate_ctrl_if #(parameter int NREQ = 4);
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] ack;
   logic            e;
   logic            busy;
`ifdef GF180MCU_CLKGATE_CTRL_TEST_EN
   logic            te;

   modport master (output req, output te, input ack, input e, input busy);
   modport slave  (input req, input te, output ack, output e, output busy);
`else
   modport master (output req, input ack, input e, input busy);
   modport slave  (input req, output ack, output e, output busy);
`endif
endinterface

// File: rtl/gf180mcu_clkgate_cnt.sv
// Loadable down-counter for wake/idle delays; load wins over decrement and it saturates at zero.
// One-cycle latency from load/decrement to count; is_one_o is a decode of the register.
module gf180mcu_clkgate_cnt #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         is_one_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/gf180mcu_clkgate_ctrl.sv
// Clock-enable sequencer for one gated clkbuf branch: wake delay before first ACK, idle hold before E falls.
// All outputs registered; GF180MCU_CLKGATE_CTRL_TEST_EN adds TE, which forces E high after the register.
module gf180mcu_clkgate_ctrl
   import gf180mcu_clkgate_pkg::*;
#(
   parameter int NREQ        = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 4
) (
   input logic                    clk_i,
   input logic                    rst_i,
   gf180mcu_clkgate_ctrl_if.slave bus
);

   localparam int            CW      = cnt_width(WAKE_CYCLES, IDLE_CYCLES);
   localparam logic [CW-1:0] WAKE_LD = CW'(WAKE_CYCLES);
   localparam logic [CW-1:0] IDLE_LD = CW'(IDLE_CYCLES);

   state_e          state_q, state_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            e_q, e_d;
   logic            busy_q, busy_d;
   logic            cnt_load, cnt_dec, cnt_is_one;
   logic [CW-1:0]   cnt_val;
   logic            req_any;

   assign req_any = |bus.req;

   always_comb begin
      state_d  = state_q;
      ack_d    = '0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      cnt_val  = IDLE_LD;
      case (state_q)
         ST_OFF: begin
            if (req_any) begin
               state_d  = ST_WAKE;
               cnt_load = 1'b1;
               cnt_val  = WAKE_LD;
            end
         end
         ST_WAKE: begin
            if (cnt_is_one) begin
               if (req_any) begin
                  state_d = ST_ON;
                  ack_d   = bus.req;
               end else begin
                  state_d  = ST_HOLD;
                  cnt_load = 1'b1;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ON: begin
            ack_d = bus.req;
            if (!req_any) begin
               state_d  = ST_HOLD;
               cnt_load = 1'b1;
            end
         end
         ST_HOLD: begin
            // A request on the expiry edge keeps the branch on; the clock never stopped.
            if (req_any) begin
               state_d = ST_ON;
               ack_d   = bus.req;
            end else if (cnt_is_one) begin
               state_d = ST_OFF;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = ST_OFF;
      endcase
      e_d    = (state_d != ST_OFF);
      busy_d = (state_d != ST_OFF);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_OFF;
         ack_q   <= '0;
         e_q     <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         e_q     <= e_d;
         busy_q  <= busy_d;
      end
   end

   gf180mcu_clkgate_cnt #(.W(CW)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_val),
      .dec_i      (cnt_dec),
      .is_one_o   (cnt_is_one)
   );

   assign bus.ack  = ack_q;
   assign bus.busy = busy_q;
`ifdef GF180MCU_CLKGATE_CTRL_TEST_EN
   assign bus.e    = e_q | bus.te;
`else
   assign bus.e    = e_q;
`endif

endmodule

// File: tb/tb_gf180mcu_clkgate_ctrl.sv
// Scoreboarded bench: a per-edge reference model pushes expected outputs, a monitor pops and compares.
// Directed scenarios (wake, second requester, idle timeout, rescue, expiry race, reset) then random traffic.
module tb_gf180mcu_clkgate_ctrl;

   localparam int NREQ = 4;
   localparam int WAKE = 2;
   localparam int IDLE = 4;

   typedef struct {
      logic [NREQ-1:0] ack;
      logic            e;
      logic            busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gf180mcu_clkgate_ctrl_if #(.NREQ(NREQ)) bus ();

   gf180mcu_clkgate_ctrl #(
      .NREQ        (NREQ),
      .WAKE_CYCLES (WAKE),
      .IDLE_CYCLES (IDLE)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // Reference model: the branch is either unpowered, waking (counting down edges),
   // or awake, in which case every grant simply mirrors the sampled requests and
   // power is dropped once IDLE+1 consecutive all-zero edges have been seen.
   bit powered   = 1'b0;
   int wake_left = 0;
   int zero_run  = 0;

   always @(posedge clk) begin
      exp_t            x;
      logic [NREQ-1:0] r;
      r     = bus.req;
      x.ack = '0;
      if (rst) begin
         powered   = 1'b0;
         wake_left = 0;
         zero_run  = 0;
      end else if (!powered) begin
         if (r != '0) begin
            powered   = 1'b1;
            wake_left = WAKE;
            zero_run  = 0;
         end
      end else begin
         if (wake_left > 0) wake_left--;
         if (wake_left == 0) begin
            zero_run = (r == '0) ? zero_run + 1 : 0;
            if (zero_run > IDLE) begin
               powered  = 1'b0;
               zero_run = 0;
            end else begin
               x.ack = r;
            end
         end
      end
      x.busy = powered;
`ifdef GF180MCU_CLKGATE_CTRL_TEST_EN
      x.e = powered | bus.te;
`else
      x.e = powered;
`endif
      q.push_back(x);
   end

   always begin
      exp_t x;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         x = q.pop_front();
         chk("ack",  32'(bus.ack),  32'(x.ack));
         chk("e",    32'(bus.e),    32'(x.e));
         chk("busy", 32'(bus.busy), 32'(x.busy));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst     = 1'b1;
      bus.req = '0;
`ifdef GF180MCU_CLKGATE_CTRL_TEST_EN
      bus.te  = 1'b0;
`endif
      cycles(2);
      chk("reset_ack",  32'(bus.ack),  32'd0);
      chk("reset_e",    32'(bus.e),    32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      cycles(2);

      // Cold wake, second requester joins, then idle timeout to OFF.
      bus.req = 4'b0001; cycles(4);
      bus.req = 4'b0101; cycles(3);
      bus.req = 4'b0000; cycles(IDLE + 3);

      // Rescue in HOLD two edges after the last request dropped.
      bus.req = 4'b0001; cycles(4);
      bus.req = 4'b0000; cycles(2);
      bus.req = 4'b0010; cycles(3);

      // Request lands exactly on the HOLD expiry edge.
      bus.req = 4'b0000; cycles(IDLE);
      bus.req = 4'b1000; cycles(3);

      // Asynchronous reset while granted, requests held through release.
      bus.req = 4'b0011; cycles(2);
      chk("pre_reset_ack", 32'(bus.ack), 32'h3);
      rst = 1'b1;
      #1;
      chk("async_reset_ack",  32'(bus.ack),  32'd0);
      chk("async_reset_e",    32'(bus.e),    32'd0);
      chk("async_reset_busy", 32'(bus.busy), 32'd0);
      cycles(1);
      rst = 1'b0;
      cycles(WAKE + 3);
      bus.req = 4'b0000; cycles(IDLE + 3);

`ifdef GF180MCU_CLKGATE_CTRL_TEST_EN
      bus.te = 1'b1;
      #1;
      chk("te_forces_e", 32'(bus.e),   32'd1);
      chk("te_no_ack",   32'(bus.ack), 32'd0);
      cycles(3);
      bus.te = 1'b0;
      cycles(1);
`endif

      // Random traffic: runs of idle or random request patterns of random length.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 2) == 0) bus.req = '0;
         else                           bus.req = NREQ'($urandom_range(0, 15));
         cycles($urandom_range(1, 8));
      end
      bus.req = '0;
      cycles(IDLE + WAKE + 4);
      chk("final_e", 32'(bus.e), 32'd0);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
